// File: rtl/rgb_pkg.sv
// Shared types and helpers for the RGB LED colour sequencer.
package rgb_pkg;

  typedef enum logic [2:0] {
    RED     = 3'd0,
    YELLOW  = 3'd1,
    GREEN   = 3'd2,
    CYAN    = 3'd3,
    BLUE    = 3'd4,
    MAGENTA = 3'd5
  } colour_e;

  localparam int NUM_COLOURS = 6;

  localparam colour_e LAST_COLOUR = colour_e'(3'(NUM_COLOURS - 1));

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } mode_e;

  // Map a colour to its {r,g,b} channel enables; unused codes stay dark.
  function automatic logic [2:0] colour_rgb(input colour_e c);
    logic [2:0] rgb;
    case (c)
      RED:     rgb = 3'b100;
      YELLOW:  rgb = 3'b110;
      GREEN:   rgb = 3'b010;
      CYAN:    rgb = 3'b011;
      BLUE:    rgb = 3'b001;
      MAGENTA: rgb = 3'b101;
      default: rgb = 3'b000;
    endcase
    return rgb;
  endfunction

  // Next colour in the sequence; the last colour (and any illegal code) wraps to RED.
  function automatic colour_e colour_next(input colour_e c);
    colour_e n;
    if (c >= LAST_COLOUR) begin
      n = RED;
    end else begin
      n = colour_e'(c + 3'd1);
    end
    return n;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw active-low button conditioner: 2-flop synchroniser, stability counter,
// and a single-cycle pulse when the accepted level goes from released to pressed.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_r;
  logic          raw_s;
  logic [CW-1:0] cnt_r;
  logic          level_r;
  logic          level_d_r;
  logic          press_r;

  // Bring the asynchronous pin into the clock domain; idle (released) is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], btn_n};
    end
  end

  assign raw_s = ~sync_r[1];

  // Accept a new level only after an unbroken run of disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= '0;
      level_r <= 1'b0;
    end else begin
      if (raw_s != level_r) begin
        if (cnt_r == CNT_LAST) begin
          level_r <= raw_s;
          cnt_r   <= '0;
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end else begin
        cnt_r <= '0;
      end
    end
  end

  // Registered rising-edge detect on the accepted level; release gives no pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d_r <= 1'b0;
      press_r   <= 1'b0;
    end else begin
      level_d_r <= level_r;
      press_r   <= level_r & ~level_d_r;
    end
  end

  assign level = level_r;
  assign press = press_r;

endmodule

// File: rtl/rgb_sequencer_fsm.sv
// Two-button RGB LED sequencer: MANUAL/AUTO mode FSM stepping a six-colour
// sequence, with PWM-dimmed, registered active-low LED drive.
module rgb_sequencer_fsm
  import rgb_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int STEP_CYCLES     = 6000000,
  parameter int PWM_BITS        = 8,
  parameter int DUTY            = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_next_n,
  input  logic       btn_mode_n,
  output logic       led_r_n,
  output logic       led_g_n,
  output logic       led_b_n,
  output logic [2:0] colour_idx,
  output logic       auto_mode
);

  localparam int TW = $clog2(STEP_CYCLES);
  localparam logic [TW-1:0]     STEP_LAST = TW'(STEP_CYCLES - 1);
  localparam logic [PWM_BITS:0] DUTY_V    = DUTY[PWM_BITS:0];

  logic                next_press_s;
  logic                mode_press_s;
  logic                next_level_s;
  logic                mode_level_s;
  logic                unused_levels_s;

  mode_e               mode_r;
  colour_e             colour_r;
  logic [TW-1:0]       timer_r;
  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic [2:0]          rgb_s;
  logic                pwm_on_s;
  logic [2:0]          enable_s;
  logic                led_r_n_r;
  logic                led_g_n_r;
  logic                led_b_n_r;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_next_n),
    .level (next_level_s),
    .press (next_press_s)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_mode_n),
    .level (mode_level_s),
    .press (mode_press_s)
  );

  // Only the press pulses drive the sequencer; the held levels are not needed here.
  assign unused_levels_s = next_level_s & mode_level_s;

  // Mode FSM with colour register and AUTO dwell timer; a mode press overrides a next press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r   <= MANUAL;
      colour_r <= RED;
      timer_r  <= '0;
    end else begin
      if (mode_press_s) begin
        timer_r <= '0;
        case (mode_r)
          MANUAL:  mode_r <= AUTO;
          AUTO:    mode_r <= MANUAL;
          default: mode_r <= MANUAL;
        endcase
      end else begin
        case (mode_r)
          MANUAL: begin
            timer_r <= '0;
            if (next_press_s) begin
              colour_r <= colour_next(colour_r);
            end else begin
              colour_r <= colour_r;
            end
          end
          AUTO: begin
            // Expiry and a next press in the same cycle still advance only once.
            if (next_press_s || (timer_r == STEP_LAST)) begin
              colour_r <= colour_next(colour_r);
              timer_r  <= '0;
            end else begin
              timer_r <= timer_r + TW'(1);
            end
          end
          default: begin
            mode_r  <= MANUAL;
            timer_r <= '0;
          end
        endcase
      end
    end
  end

  // Free-running PWM period counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_r <= '0;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
    end
  end

  // Channel enables: colour bit gated by the duty compare, done one bit wider so full-on is reachable.
  always_comb begin
    rgb_s    = colour_rgb(colour_r);
    pwm_on_s = ({1'b0, pwm_cnt_r} < DUTY_V);
    enable_s = rgb_s & {3{pwm_on_s}};
  end

  // Registered active-low LED drive; dark while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_r_n_r <= 1'b1;
      led_g_n_r <= 1'b1;
      led_b_n_r <= 1'b1;
    end else begin
      led_r_n_r <= ~enable_s[2];
      led_g_n_r <= ~enable_s[1];
      led_b_n_r <= ~enable_s[0];
    end
  end

  assign led_r_n    = led_r_n_r;
  assign led_g_n    = led_g_n_r;
  assign led_b_n    = led_b_n_r;
  assign colour_idx = colour_r;
  assign auto_mode  = (mode_r == AUTO);

endmodule

// File: tb/tb_rgb_sequencer_fsm.sv
// Scoreboard bench for rgb_sequencer_fsm: stimulus queues expected
// (mode, colour, cycle) events; a negedge monitor pops and compares on every state change.
module tb_rgb_sequencer_fsm;

  typedef struct {
    logic       mode;
    logic [2:0] colour;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       next_n;
  logic       mode_n;
  logic       led_r_n;
  logic       led_g_n;
  logic       led_b_n;
  logic [2:0] colour_idx;
  logic       auto_mode;

  logic       rst3_n;
  logic       next3_n;
  logic       mode3_n;
  logic       led3_r_n;
  logic       led3_g_n;
  logic       led3_b_n;
  logic [2:0] colour3_idx;
  logic       auto3_mode;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t q[$];

  rgb_sequencer_fsm #(
    .DEBOUNCE_CYCLES(4), .STEP_CYCLES(10), .PWM_BITS(3), .DUTY(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_next_n (next_n),
    .btn_mode_n (mode_n),
    .led_r_n    (led_r_n),
    .led_g_n    (led_g_n),
    .led_b_n    (led_b_n),
    .colour_idx (colour_idx),
    .auto_mode  (auto_mode)
  );

  rgb_sequencer_fsm #(
    .DEBOUNCE_CYCLES(4), .STEP_CYCLES(10), .PWM_BITS(3), .DUTY(3)
  ) dut3 (
    .clk        (clk),
    .rst_n      (rst3_n),
    .btn_next_n (next3_n),
    .btn_mode_n (mode3_n),
    .led_r_n    (led3_r_n),
    .led_g_n    (led3_g_n),
    .led_b_n    (led3_b_n),
    .colour_idx (colour3_idx),
    .auto_mode  (auto3_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] rgb_of(input logic [2:0] c);
    case (c)
      3'd0:    return 3'b100;
      3'd1:    return 3'b110;
      3'd2:    return 3'b010;
      3'd3:    return 3'b011;
      3'd4:    return 3'b001;
      3'd5:    return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input logic m, input logic [2:0] c, input int at);
    exp_t e;
    e.mode = m;
    e.colour = c;
    e.cyc = at;
    q.push_back(e);
  endtask

  task automatic press(input logic do_next, input logic do_mode, input int hold);
    if (do_next) next_n = 1'b0;
    if (do_mode) mode_n = 1'b0;
    repeat (hold) @(negedge clk);
    next_n = 1'b1;
    mode_n = 1'b1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Monitor: every change of {auto_mode, colour_idx} must match the queue head.
  logic [3:0] prev_state  = 4'b0000;
  logic       led_pending = 1'b0;
  logic [2:0] led_exp_n   = 3'b111;

  always @(negedge clk) begin
    exp_t e;
    logic [2:0] pins;
    if (led_pending) begin
      led_pending = 1'b0;
      pins = {led_r_n, led_g_n, led_b_n};
      if (rst_n) chk("led_pins", int'(pins), int'(led_exp_n));
    end
    if ({auto_mode, colour_idx} != prev_state) begin
      prev_state = {auto_mode, colour_idx};
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event actual mode=%0d colour=%0d at cycle %0d required no change",
                 auto_mode, colour_idx, cyc);
      end else begin
        e = q.pop_front();
        chk("event_mode", int'(auto_mode), int'(e.mode));
        chk("event_colour", int'(colour_idx), int'(e.colour));
        if (e.cyc >= 0) chk("event_cycle", cyc, e.cyc);
        led_pending = 1'b1;
        led_exp_n   = ~rgb_of(e.colour);
      end
    end
  end

  initial begin
    int k;
    int col;
    int lowr, lowg, lowb;
    rst_n = 1'b0; rst3_n = 1'b0;
    next_n = 1'b1; mode_n = 1'b1;
    next3_n = 1'b1; mode3_n = 1'b1;
    col = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; rst3_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state: RED, MANUAL, red LED lit at full duty.
    chk("reset_colour", int'(colour_idx), 0);
    chk("reset_auto", int'(auto_mode), 0);
    chk("reset_led_r", int'(led_r_n), 0);
    chk("reset_led_g", int'(led_g_n), 1);
    chk("reset_led_b", int'(led_b_n), 1);

    // One long next press: exactly one advance, 8 cycles after the pin falls.
    k = cyc; col = (col + 1) % 6; push(1'b0, 3'(col), k + 8);
    press(1'b1, 1'b0, 10);
    repeat (12) @(negedge clk);

    // Bouncing contact: 3 low / 1 high never reaches the debounce threshold.
    repeat (4) begin
      next_n = 1'b0;
      repeat (3) @(negedge clk);
      next_n = 1'b1;
      @(negedge clk);
    end
    repeat (12) @(negedge clk);

    // Six clean manual presses, crossing the 5 -> 0 wrap.
    repeat (6) begin
      k = cyc; col = (col + 1) % 6; push(1'b0, 3'(col), k + 8);
      press(1'b1, 1'b0, 10);
      repeat (12) @(negedge clk);
    end

    // AUTO: enter at k+8, steps at k+18 and k+28, next press lands with timer=6
    // (advance at k+35), dwell restarts so the next step is k+45; then both
    // buttons together at k+54 leave AUTO without advancing.
    k = cyc;
    push(1'b1, 3'(col), k + 8);
    col = (col + 1) % 6; push(1'b1, 3'(col), k + 18);
    col = (col + 1) % 6; push(1'b1, 3'(col), k + 28);
    col = (col + 1) % 6; push(1'b1, 3'(col), k + 35);
    col = (col + 1) % 6; push(1'b1, 3'(col), k + 45);
    push(1'b0, 3'(col), k + 54);
    press(1'b0, 1'b1, 8);
    wait_until(k + 27);
    press(1'b1, 1'b0, 8);
    wait_until(k + 46);
    press(1'b1, 1'b1, 8);
    repeat (30) @(negedge clk);

    // Async reset mid-AUTO: immediate return to reset values, no event on release.
    k = cyc;
    push(1'b1, 3'(col), k + 8);
    press(1'b0, 1'b1, 8);
    wait_until(k + 12);
    push(1'b0, 3'd0, -1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_colour", int'(colour_idx), 0);
    chk("async_rst_auto", int'(auto_mode), 0);
    chk("async_rst_leds", int'({led_r_n, led_g_n, led_b_n}), 7);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_colour", int'(colour_idx), 0);
    chk("post_rst_auto", int'(auto_mode), 0);

    // DUTY=3 build in RED: red pin low 3 of every 8 cycles, others dark.
    lowr = 0; lowg = 0; lowb = 0;
    repeat (24) begin
      @(negedge clk);
      if (!led3_r_n) lowr++;
      if (!led3_g_n) lowg++;
      if (!led3_b_n) lowb++;
    end
    chk("pwm3_red_low", lowr, 9);
    chk("pwm3_green_low", lowg, 0);
    chk("pwm3_blue_low", lowb, 0);
    chk("pwm3_colour", int'(colour3_idx), 0);
    chk("pwm3_auto", int'(auto3_mode), 0);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
